// File: rtl/lsu_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store control stage sitting directly in front of a byte-addressable
//   data memory. It accepts one core request at a time over a valid/ready
//   handshake and checks funct3 legality and address range. Aligned accesses
//   go to memory as a single access. Misaligned accesses are either split into
//   byte accesses or rejected. Exactly one response (rdata/err) is returned
//   per accepted request.
//
//   Optional feature macro: MISALIGN_SPLIT_EN
//     defined   : misaligned, legal, in-range accesses are split into N byte
//                 accesses (BYTE state) and succeed.
//     undefined : misaligned requests respond with err=1 and never touch
//                 memory; the BYTE state and its counter are not built.
//
// Ports
//   clk, reset    single clock, synchronous active-high reset
//   req_valid     core request valid
//   req_ready     request accepted when high (IDLE only)
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   req_funct3    RV32I load/store funct3
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     extended load data (0 for stores and errors)
//   rsp_err       illegal funct3, out of range, or rejected misalignment
//   mem_wr_en     memory write enable (never high while reset is asserted)
//   mem_addr      memory byte address
//   mem_wr_data   memory write data
//   mem_funct3    memory access size/type
//   mem_rd_data   combinational memory read data, same cycle as mem_addr
// ----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
`ifdef MISALIGN_SPLIT_EN
    S_BYTE   = 2'd3,
`endif
    S_RESP   = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [2:0]          F3_LB     = 3'b000;
  localparam logic [2:0]          F3_LW     = 3'b010;
  localparam logic [2:0]          F3_LBU    = 3'b100;

  // Access size in bytes from funct3[1:0]; illegal encodings are rejected
  // separately, so their size value does not matter.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) funct3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    funct3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

`ifdef MISALIGN_SPLIT_EN
  // Sign/zero extension of assembled byte-lane data for a split load.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0]            f3,
                                                        input logic [DATA_WIDTH-1:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(raw[7:0]);
    h = $signed(raw[15:0]);
    case (f3)
      3'b000:  load_extend = DATA_WIDTH'(b);
      3'b001:  load_extend = DATA_WIDTH'(h);
      3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
      3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction
`endif

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    mem_wr_en_raw;
`ifdef MISALIGN_SPLIT_EN
  logic [1:0]              k_q, k_d;
  logic [DATA_WIDTH-1:0]   merged;
`endif

  // Request classification, evaluated on the raw request inputs in IDLE.
  logic [2:0]              req_n;
  logic [2:0]              req_nm1;
  logic [1:0]              req_mask;
  logic [ADDR_WIDTH:0]     req_last;
  logic                    req_legal;
  logic                    req_oob;
  logic                    req_aligned;

  always_comb begin
    req_n       = access_bytes(req_funct3);
    req_nm1     = req_n - 3'd1;
    req_mask    = req_nm1[1:0];
    // One extra bit so an address near the top of the space cannot wrap.
    req_last    = {1'b0, req_addr} + {{(ADDR_WIDTH-2){1'b0}}, req_nm1};
    req_legal   = funct3_legal(req_we, req_funct3);
    req_oob     = (req_last >= MEM_LIMIT);
    req_aligned = ((req_addr[1:0] & req_mask) == 2'b00);
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    funct3_d      = funct3_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
`ifdef MISALIGN_SPLIT_EN
    k_d           = k_q;
    merged        = rdata_q;
`endif
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    mem_wr_en_raw = 1'b0;
    mem_addr      = '0;
    mem_wr_data   = '0;
    mem_funct3    = F3_LW;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (!req_legal || req_oob) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_aligned) begin
            state_d = S_ACCESS;
          end else begin
`ifdef MISALIGN_SPLIT_EN
            k_d     = 2'd0;
            state_d = S_BYTE;
`else
            err_d   = 1'b1;
            state_d = S_RESP;
`endif
          end
        end
      end

      S_ACCESS: begin
        mem_addr      = addr_q;
        mem_funct3    = funct3_q;
        mem_wr_data   = wdata_q;
        mem_wr_en_raw = we_q;
        if (!we_q) rdata_d = mem_rd_data;
        state_d = S_RESP;
      end

`ifdef MISALIGN_SPLIT_EN
      S_BYTE: begin
        mem_addr      = addr_q + ADDR_WIDTH'(k_q);
        mem_funct3    = we_q ? F3_LB : F3_LBU;
        mem_wr_data   = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{k_q, 3'b000} +: 8]};
        mem_wr_en_raw = we_q;
        // Byte k lands in lane k; the LBU result is zero-extended so only
        // its low byte carries data.
        merged[{k_q, 3'b000} +: 8] = mem_rd_data[7:0];
        if (!we_q) rdata_d = merged;
        if ({1'b0, k_q} == access_bytes(funct3_q) - 3'd1) begin
          if (!we_q) rdata_d = load_extend(funct3_q, merged);
          state_d = S_RESP;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
`endif

      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A reset cycle must never write memory, even mid-access.
  assign mem_wr_en = mem_wr_en_raw && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
`ifdef MISALIGN_SPLIT_EN
      k_q     <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MISALIGN_SPLIT_EN
      k_q     <= k_d;
`endif
    end
  end

  // Request payload and response data are only observed in states entered
  // after they are loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    we_q     <= we_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    funct3_q <= funct3_d;
    rdata_q  <= rdata_d;
    err_q    <= err_d;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 256;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [2:0]    req_funct3;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rd_data;

  lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_funct3  (req_funct3),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_funct3  (mem_funct3),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails   = 0;

  // ---------------- memory attached to the DUT ----------------
  logic [7:0]  mem [0:MB-1];
  logic        clear_mem;
  logic [31:0] mem_raw;

  function automatic int fsize(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    end else if (mem_wr_en) begin
      for (int i = 0; i < fsize(mem_funct3); i++)
        if (mem_addr < 32'(MB - i)) mem[int'(mem_addr) + i] <= mem_wr_data[8*i +: 8];
    end
  end

  always_comb begin
    mem_raw = '0;
    for (int i = 0; i < 4; i++)
      if (mem_addr < 32'(MB - i)) mem_raw[8*i +: 8] = mem[int'(mem_addr) + i];
  end

  always_comb begin
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{mem_raw[7]}}, mem_raw[7:0]};
      3'b001:  mem_rd_data = {{16{mem_raw[15]}}, mem_raw[15:0]};
      3'b100:  mem_rd_data = {24'h0, mem_raw[7:0]};
      3'b101:  mem_rd_data = {16'h0, mem_raw[15:0]};
      default: mem_rd_data = mem_raw;
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:MB-1];

  typedef struct {
    logic [31:0] rd;
    bit          err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Architectural effect of one request: updates ref_mem for stores and
  // returns the response plus its latency in cycles after acceptance.
  function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3,
                                output logic [31:0] rd, output bit err, output int lat);
    int          n;
    bit          legal;
    longint      last;
    logic [31:0] raw;
    n     = fsize(f3);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    last  = longint'(a) + longint'(n) - 1;
    rd    = '0;
    err   = 1'b0;
    lat   = 1;
    if (!legal || last >= MB) begin
      err = 1'b1;
      return;
    end
    if ((a % n) != 0) begin
      if (!SPLIT) begin
        err = 1'b1;
        return;
      end
      lat = n + 1;
    end else begin
      lat = 2;
    end
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      raw = '0;
      for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_mem[int'(a) + i];
      case (f3)
        3'd0:    rd = {{24{raw[7]}}, raw[7:0]};
        3'd1:    rd = {{16{raw[15]}}, raw[15:0]};
        3'd4:    rd = {24'h0, raw[7:0]};
        3'd5:    rd = {16'h0, raw[15:0]};
        default: rd = raw;
      endcase
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp cyc=%0d rdata=%08h err=%0b, no response expected",
                 cyc, rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e.rd || rsp_err !== e.err || cyc != e.cyc) begin
          fails++;
          $display("FAIL rsp got rdata=%08h err=%0b cyc=%0d, expected rdata=%08h err=%0b cyc=%0d",
                   rsp_rdata, rsp_err, cyc, e.rd, e.err, e.cyc);
        end
      end
    end
    if (req_ready && !reset) begin
      vectors++;
      if (rsp_valid !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== '0 ||
          mem_funct3 !== 3'b010 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs cyc=%0d got rv=%0b we=%0b addr=%08h f3=%03b rd=%08h err=%0b, expected 0/0/0/010/0/0",
                 cyc, rsp_valid, mem_wr_en, mem_addr, mem_funct3, rsp_rdata, rsp_err);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  endtask

  // Called at a negedge; returns at the negedge where req_ready is high.
  // While busy, random requests are presented and must be ignored.
  task automatic wait_idle();
    int guard;
    guard = 0;
    while (req_ready !== 1'b1) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom_range(0, 7));
      @(negedge clk);
      guard++;
      if (guard > 40) begin
        vectors++;
        fails++;
        $display("FAIL idle_timeout cyc=%0d req_ready=%0b, expected 1 within 40 cycles", cyc, req_ready);
        finish_run();
      end
    end
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
    exp_t e;
    int   lat;
    wait_idle();
    model(we, a, wd, f3, e.rd, e.err, lat);
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    @(negedge clk);
  endtask

  // Store that is killed by reset in cycle rst_at after acceptance; the
  // first nwritten bytes are expected to have reached memory.
  task automatic abort_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                             input int rst_at, input int nwritten);
    wait_idle();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (rst_at - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < nwritten; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    vectors++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_ready got %0b, expected 1", req_ready);
    end
  endtask

  initial begin
    int          nbad;
    bit          we;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] word;

    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    reset      = 1'b1;
    clear_mem  = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = 3'b010;
    repeat (3) @(negedge clk);
    clear_mem = 1'b0;

    // Reset state while reset is still held.
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_wr_en !== 1'b0 ||
        rsp_rdata !== '0 || rsp_err !== 1'b0 || mem_addr !== '0 || mem_funct3 !== 3'b010) begin
      fails++;
      $display("FAIL reset_state got rdy=%0b rv=%0b we=%0b rd=%08h err=%0b addr=%08h f3=%03b, expected 1/0/0/0/0/0/010",
               req_ready, rsp_valid, mem_wr_en, rsp_rdata, rsp_err, mem_addr, mem_funct3);
    end
    reset = 1'b0;
    @(negedge clk);

    // Word store/load round trip.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    issue(1'b0, 32'h10, 32'h0, 3'b010);
    // Byte store, signed and unsigned reload.
    issue(1'b1, 32'h20, 32'h00000080, 3'b000);
    issue(1'b0, 32'h20, 32'h0, 3'b000);
    issue(1'b0, 32'h20, 32'h0, 3'b100);
    // Misaligned word store and reloads (split or rejected per build).
    issue(1'b1, 32'h05, 32'h11223344, 3'b010);
    issue(1'b0, 32'h05, 32'h0, 3'b010);
    issue(1'b0, 32'h07, 32'h0, 3'b001);
    issue(1'b0, 32'h03, 32'h0, 3'b001);
    // Range and legality boundaries.
    issue(1'b0, 32'hFE, 32'h0, 3'b010);
    issue(1'b1, 32'h30, 32'h12345678, 3'b011);
    issue(1'b0, 32'h30, 32'h0, 3'b010);
    issue(1'b0, 32'hFC, 32'h0, 3'b010);
    issue(1'b0, 32'hFF, 32'h0, 3'b000);
    issue(1'b0, 32'hFF, 32'h0, 3'b001);
    issue(1'b0, 32'hFFFFFFFE, 32'h0, 3'b010);
    issue(1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 3'b000);
    issue(1'b0, 32'h10, 32'h0, 3'b110);

    // Reset during an aligned store's single access: nothing is written.
    abort_store(32'h40, 32'hCAFEF00D, 3'b010, 1, 0);
`ifdef MISALIGN_SPLIT_EN
    // Reset during the second byte of a split store: only byte 0 is written.
    abort_store(32'h01, 32'hA1B2C3D4, 3'b010, 2, 1);
`endif
    issue(1'b0, 32'h40, 32'h0, 3'b010);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       a = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
        1:       a = 32'($urandom_range(240, 255));
        default: a = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'd0;
          1:       f3 = 3'd1;
          2:       f3 = 3'd2;
          3:       f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      issue(we, a, $urandom, f3);
    end

    wait_idle();
    req_valid = 1'b0;
    repeat (5) @(negedge clk);

    vectors++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_rsp got %0d outstanding, expected 0", exp_q.size());
    end

    word = {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]};
    vectors++;
    if (mem[8'h10] !== 8'hEF || mem[8'h11] !== 8'hBE) begin
      fails++;
      $display("FAIL mem_0x10 got %08h, expected low bytes BE,EF", word);
    end

    nbad = 0;
    for (int i = 0; i < MB; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (nbad < 4) $display("FAIL mem_byte[%02h] got %02h, expected %02h", i, mem[i], ref_mem[i]);
        nbad++;
      end
    end
    vectors++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL mem_image got %0d differing bytes, expected 0", nbad);
    end

    finish_run();
  end

endmodule
